// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between the parallel host logic and the buffered UART transmitter.
interface uart_tx_buffered_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a baud-timed serialiser.
module uart_tx_buffered #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_buffered_if.slave   bus,
    output logic                tx,
    output logic                busy,
    output logic [ADDR_W:0]     count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CNT_FW       = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic [ADDR_W-1:0]    wptr_q, wptr_d;
    logic [ADDR_W-1:0]    rptr_q, rptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [7:0]           mem_q [FIFO_DEPTH];

    logic                 baud_tick;
    logic                 push;
    logic                 pop;
    logic                 ready_c;

    assign ready_c   = (count_q != CNT_FW'(FIFO_DEPTH));
    assign baud_tick = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    assign push      = bus.valid && ready_c;
    // A pop only ever starts a frame from idle or straight out of a finished stop bit
    assign pop       = (count_q != '0) &&
                       ((state_q == IDLE) || ((state_q == STOP) && baud_tick));

    assign bus.ready = ready_c;
    assign tx        = tx_q;
    assign count     = count_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);

    // State and datapath registers; reset aborts any frame and empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.data;
        end
    end

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (pop) state_d = START;
            START: if (baud_tick) state_d = DATA;
            DATA:  if (baud_tick && (bit_q == 3'd7)) state_d = STOP;
            STOP:  if (baud_tick) state_d = pop ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Baud counter, bit sequencing, line level and FIFO bookkeeping
    always_comb begin
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (state_q == IDLE) begin
            baud_d = '0;
        end else begin
            baud_d = baud_tick ? '0 : baud_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: tx_d = 1'b1;
            START: begin
                if (baud_tick) begin
                    bit_d = 3'd0;
                    tx_d  = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[3'(bit_q + 3'd1)];
                    end
                end
            end
            STOP: tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase

        // Loading a new frame overrides whatever the stop bit would have done
        if (pop) begin
            shift_d = mem_q[rptr_q];
            rptr_d  = rptr_q + ADDR_W'(1);
            tx_d    = 1'b0;
            baud_d  = '0;
        end

        if (push) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_FW'(1);
            2'b01:   count_d = count_q - CNT_FW'(1);
            default: count_d = count_q;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for the buffered UART transmitter against a queue-based line model.
module tb_uart_tx_buffered;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic       tx;
    logic       busy;
    logic [3:0] count;

    uart_tx_buffered_if bus ();

    uart_tx_buffered #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (3)
    ) dut (
        .clk   (clk),
        .rst   (rst_n),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: waiting bytes, byte on the line, cycles since its start bit began
    logic [7:0] q [$];
    logic [7:0] cur;
    bit         active;
    int         t;
    logic       tx_hist [$];
    logic [7:0] exp_bytes [$];
    int         max_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic exp_tx();
        if (!active) return 1'b1;
        if (t < CPB) return 1'b0;
        if (t < 9 * CPB) return cur[(t / CPB) - 1];
        return 1'b1;
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare outputs
    task automatic step(input logic v, input logic [7:0] d, output bit pushed);
        bit do_push, do_pop;
        bus.valid = v;
        bus.data  = d;
        do_pop  = (q.size() != 0) && (!active || (t == FRAME - 1)) && rst_n;
        do_push = v && (q.size() < DEPTH) && rst_n;
        @(posedge clk);
        #1;
        if (active) begin
            if (t == FRAME - 1) active = 1'b0;
            else t++;
        end
        if (do_pop) begin
            cur    = q.pop_front();
            active = 1'b1;
            t      = 0;
        end
        if (do_push) q.push_back(d);
        pushed = do_push;
        tx_hist.push_back(tx);
        if (32'(count) > max_cnt) max_cnt = 32'(count);
        chk("tx",    32'(tx),    32'(exp_tx()));
        chk("count", 32'(count), 32'(q.size()));
        chk("ready", 32'(bus.ready), 32'(q.size() != DEPTH));
        chk("busy",  32'(busy),  32'(active || (q.size() != 0)));
    endtask

    task automatic idle(input int n);
        bit p;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, p);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bit p;
        while ((active || q.size() != 0) && n < budget) begin
            step(1'b0, 8'h00, p);
            n++;
        end
        chk("drain_done", 32'(active || q.size() != 0), 32'd0);
        idle(5);
    endtask

    // Decode frames from the recorded line, requiring them to be back to back
    task automatic check_frames(input string tag, input int from);
        int idx = -1;
        int i = from;
        logic [7:0] b;
        while (idx < 0 && i < tx_hist.size()) begin
            if (tx_hist[i] == 1'b0) idx = i;
            i++;
        end
        chk({tag, "_start_found"}, 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
            for (int k = 0; k < exp_bytes.size(); k++) begin
                int base = idx + FRAME * k;
                chk({tag, "_in_range"}, 32'(base + FRAME - 1 < tx_hist.size()), 32'd1);
                if (base + FRAME - 1 < tx_hist.size()) begin
                    chk({tag, "_startbit"}, 32'(tx_hist[base + CPB / 2]), 32'd0);
                    for (int j = 0; j < 8; j++) b[j] = tx_hist[base + CPB * (j + 1) + CPB / 2];
                    chk({tag, "_byte"}, 32'(b), 32'(exp_bytes[k]));
                    chk({tag, "_stopbit"}, 32'(tx_hist[base + 9 * CPB + CPB / 2]), 32'd1);
                end
            end
        end
    endtask

    initial begin
        bit p;
        int from;
        int n;
        bit got;

        active    = 1'b0;
        t         = 0;
        cur       = 8'h00;
        max_cnt   = 0;
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        rst_n     = 1'b0;

        // Reset held, then long idle
        idle(3);
        rst_n = 1'b1;
        idle(100);

        // Single byte
        from = tx_hist.size();
        exp_bytes = '{8'hA5};
        step(1'b1, 8'hA5, p);
        chk("single_count_after_push", 32'(count), 32'd1);
        idle(FRAME + 10);
        check_frames("single", from);

        // Three bytes on consecutive cycles
        from = tx_hist.size();
        max_cnt = 0;
        exp_bytes = '{8'h00, 8'hFF, 8'h55};
        step(1'b1, 8'h00, p);
        step(1'b1, 8'hFF, p);
        step(1'b1, 8'h55, p);
        idle(3 * FRAME + 10);
        chk("b2b_peak_count", 32'(max_cnt), 32'd2);
        check_frames("b2b", from);

        // Fill the FIFO with an incrementing pattern while the first frame runs
        from = tx_hist.size();
        exp_bytes.delete();
        for (int k = 0; k < 10; k++) exp_bytes.push_back(8'(k));
        for (int k = 0; k < 9; k++) step(1'b1, 8'(k), p);
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(bus.ready), 32'd0);
        step(1'b1, 8'h09, p);
        chk("full_blocked", 32'(p), 32'd0);
        chk("full_count_hold", 32'(count), 32'd8);
        n = 0;
        got = 1'b0;
        while (!got && n < 2 * FRAME) begin
            step(1'b1, 8'h09, got);
            n++;
        end
        chk("full_byte9_accepted", 32'(got), 32'd1);
        bus.valid = 1'b0;
        drain(12 * FRAME);
        check_frames("full", from);

        // Push on the stop-completion edge with three bytes waiting
        from = tx_hist.size();
        exp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h10 + k), p);
        chk("sim_count3", 32'(count), 32'd3);
        n = 0;
        while (!(active && t == FRAME - 1) && n < 2 * FRAME) begin
            step(1'b0, 8'h00, p);
            n++;
        end
        chk("sim_reach_stop_end", 32'(active && t == FRAME - 1), 32'd1);
        step(1'b1, 8'h14, p);
        chk("sim_count_unchanged", 32'(count), 32'd3);
        drain(8 * FRAME);
        check_frames("sim", from);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 7) == 0), 8'($urandom), p);
        end
        drain(12 * FRAME);

        // Reset during data bit 4 of 0x0F with two bytes queued
        step(1'b1, 8'h0F, p);
        step(1'b1, 8'h11, p);
        step(1'b1, 8'h22, p);
        n = 0;
        while (!(active && t == 5 * CPB + CPB / 2) && n < 2 * FRAME) begin
            step(1'b0, 8'h00, p);
            n++;
        end
        chk("rst_reach_bit4", 32'(active && t == 5 * CPB + CPB / 2), 32'd1);
        chk("rst_queued2", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx",    32'(tx),    32'd1);
        chk("rst_async_count", 32'(count), 32'd0);
        chk("rst_async_ready", 32'(bus.ready), 32'd1);
        chk("rst_async_busy",  32'(busy),  32'd0);
        q.delete();
        active = 1'b0;
        t = 0;
        idle(3);
        rst_n = 1'b1;
        idle(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter; the host-side counterpart that feeds serial data out to the PC or Nios end of the link.
- Accepts bytes from parallel logic over a valid/ready handshake and queues them in an internal FIFO.
- Serialises queued bytes on tx, using its own baud counter derived from the system clock.
- Replaces direct byte drive of the bare transmitter, so bursts are not lost while a frame is in flight.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated, must be >= 2.
- FIFO_DEPTH, 8: queue depth in bytes. Power of two, >= 2.
- ADDR_W, 3: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data  in  8  byte to enqueue.
- valid  in  1  data is valid this cycle.
- ready  out  1  FIFO can accept a byte. Equals (count != FIFO_DEPTH).
- tx  out  1  serial line; idles high. Registered output.
- busy  out  1  high while a frame is in flight or the FIFO is non-empty.
- count  out  ADDR_W+1  bytes currently queued, excluding the byte being shifted.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, busy=0, count=0, ready=1.
  - FIFO pointers cleared; state=IDLE; baud counter and bit index cleared.
  - Reset mid-frame aborts the frame; tx returns high immediately and queued bytes are discarded.
- Push: on a clock edge with valid=1 and ready=1, data is written at the write pointer, wptr increments and wraps modulo FIFO_DEPTH, and count increments.
  - valid while ready=0 is ignored; no overwrite, no error flag.
- Pop: happens only in IDLE, or at the final cycle of STOP, when count != 0.
  - The head byte is loaded into the shift register and rptr increments and wraps.
  - On that same edge tx goes 0 (start bit), the baud counter is cleared and state becomes START.
- Simultaneous push and pop on one edge: count unchanged; both pointers advance.
  - When full, ready=0 blocks the push; the slot freed by the pop is visible as ready=1 on the next cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. Go to START on pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and tx=shift[0].
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, go to STOP with tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - At completion, if count != 0, pop and go directly to START; no idle gap between frames.
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. The terminal count advances the bit; otherwise it holds the current bit.
- Frame length is exactly 10*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- Latency: a byte pushed into an empty, idle block at edge N shows count=1 after N. It is popped at edge N+1, with tx=0 from N+1; count returns to 0 after N+1.
- busy = (state != IDLE) || (count != 0). Combinational from registers.
- Widths:
  - count holds 0..FIFO_DEPTH inclusive, hence ADDR_W+1 bits.
  - Pointer wrap is natural ADDR_W-bit overflow.
- tx never glitches: it is driven from a register only.

Test Plan (bench uses CLK_FREQ=16, BAUD=1, so CLKS_PER_BIT=16):
- Reset then idle: hold rst=0 for 3 cycles, release, run 100 cycles -> tx=1, ready=1, busy=0, count=0 throughout.
- Single byte: push 0xA5 at edge N -> tx=0 during cycles N+1..N+16, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then tx=1 for 16 cycles. busy falls after edge N+160.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles -> count peaks at 2. Frames are contiguous: the stop bit of one frame is immediately followed by the start bit of the next. Total 480 cycles of activity, decoded bytes 0x00, 0xFF, 0x55.
- Full FIFO: hold valid=1 with an incrementing pattern from idle -> the first byte pops, 8 more are queued, count=8, ready=0. The 10th byte (0x09) is not accepted. After the next pop, ready=1 for one cycle and byte 0x09 is accepted.
- Simultaneous push/pop: with count=3, push on the STOP-completion edge -> count stays 3 and rptr and wptr both advance.
- Reset mid-frame: assert rst=0 during DATA bit 4 of 0x0F with 2 bytes queued -> tx=1 asynchronously, count=0. After release, no further frames and tx stays high for 200 cycles.
